// File: rtl/im_loader.sv
// im_loader: receives a byte stream, packs little-endian 32-bit words,
// writes them to instruction memory and holds the CPU until the load is done.
module im_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we_IM,
    output logic [ADDR_W-1:0] addr_wr,
    output logic [31:0]       data_wr,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] MAXW = 7'(DEPTH);

    state_t            r_state;
    logic [5:0]        r_target;
    logic [5:0]        r_words;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_bidx;
    logic [31:0]       r_word;
    logic [7:0]        r_sum;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr_wr;
    logic [31:0]       r_data_wr;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_hold;

    logic [5:0]        w_clamp;
    logic              w_accept;

    // Requested length limited to the addressable depth
    assign w_clamp  = ({1'b0, word_count} > MAXW) ? MAXW[5:0] : word_count;
    assign w_accept = r_ready && byte_valid;

    // Load sequencer with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_target  <= '0;
            r_words   <= '0;
            r_addr    <= '0;
            r_bidx    <= '0;
            r_word    <= '0;
            r_sum     <= '0;
            r_we      <= 1'b0;
            r_addr_wr <= '0;
            r_data_wr <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hold    <= 1'b1;
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_sum   <= '0;
                        r_addr  <= '0;
                        r_bidx  <= '0;
                        r_words <= '0;
                        if (word_count == 6'd0) begin
                            r_state <= DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state  <= RECV;
                            r_target <= w_clamp;
                            r_ready  <= 1'b1;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                            r_hold   <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (w_accept) begin
                        r_word[r_bidx*8 +: 8] <= byte_in;
                        r_sum  <= r_sum + byte_in;
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_state   <= WRITE;
                            r_ready   <= 1'b0;
                            r_we      <= 1'b1;
                            r_addr_wr <= r_addr;
                            r_data_wr <= {byte_in, r_word[23:0]};
                        end
                    end
                end
                WRITE: begin
                    r_addr  <= r_addr + 1'b1;
                    r_words <= r_words + 6'd1;
                    if (r_words + 6'd1 == r_target) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hold  <= 1'b0;
                    end else begin
                        r_state <= RECV;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign byte_ready = r_ready;
    assign we_IM      = r_we;
    assign addr_wr    = r_addr_wr;
    assign data_wr    = r_data_wr;
    assign cpu_hold   = r_hold;
    assign busy       = r_busy;
    assign done       = r_done;
    assign checksum   = r_sum;

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter DEPTH, default 32, SHALL set the number of instruction words the loader can address.
REQ-002 Parameter ADDR_W, default 5, SHALL set the write-address width, with 2^ADDR_W = DEPTH.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a load; sampled in IDLE or DONE only.
REQ-006 word_count  input  6  SHALL give the number of 32-bit words to load, sampled with start.
REQ-007 byte_in  input  8  SHALL carry the incoming program byte.
REQ-008 byte_valid  input  1  SHALL qualify byte_in.
REQ-009 byte_ready  output  1  SHALL indicate the loader accepts byte_in this cycle.
REQ-010 we_IM  output  1  SHALL be a one-cycle write strobe to the instruction memory.
REQ-011 addr_wr  output  ADDR_W  SHALL be the instruction-memory word address for the write.
REQ-012 data_wr  output  32  SHALL be the instruction word to write.
REQ-013 cpu_hold  output  1  SHALL hold the CPU in reset while high.
REQ-014 busy  output  1  SHALL be high in RECV and WRITE.
REQ-015 done  output  1  SHALL be high in DONE.
REQ-016 checksum  output  8  SHALL be the modulo-256 sum of all bytes accepted in the current load.

Function
REQ-017 FSM SHALL have states IDLE, RECV, WRITE, DONE.
REQ-018 A byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1.
REQ-019 byte_ready SHALL be 1 only in RECV.
REQ-020 IDLE/DONE + start with word_count 1..32 SHALL go to RECV next cycle; word_addr, byte index and checksum cleared to 0; target latched.
REQ-021 word_count >32 SHALL be clamped to 32 when latched.
REQ-022 IDLE/DONE + start with word_count=0 SHALL go directly to DONE; no writes issued; checksum cleared to 0.
REQ-023 Bytes SHALL be assembled little-endian: byte 0 into bits[7:0], byte 3 into bits[31:24].
REQ-024 Acceptance of the 4th byte of a word SHALL move RECV to WRITE on the next edge.
REQ-025 In WRITE, we_IM=1 for exactly one cycle with addr_wr = current word address and data_wr = assembled word; byte_ready=0.
REQ-026 After WRITE, word address SHALL increment; if words written = target, go to DONE, else back to RECV.
REQ-027 The address SHALL wrap modulo DEPTH; with the 32-word clamp, word 31 is the last write and no wrap occurs within one load.
REQ-028 Write latency SHALL be 1 cycle from the 4th byte accept edge to the we_IM=1 cycle.
REQ-029 checksum SHALL update on every accepted byte, modulo 256.
REQ-030 start SHALL be ignored in RECV and WRITE.
REQ-031 byte_valid SHALL be ignored in IDLE, WRITE and DONE; the byte is neither consumed nor counted.
REQ-032 cpu_hold SHALL be 1 in IDLE, RECV and WRITE, and 0 only in DONE.
REQ-033 start in DONE SHALL start a reload; cpu_hold rises on the next cycle.
REQ-034 we_IM, addr_wr and data_wr SHALL be registered outputs; addr_wr/data_wr hold their last values when we_IM=0.

Reset
REQ-035 reset=1 at a clock edge SHALL force IDLE, byte_ready=0, we_IM=0, addr_wr=0, data_wr=0, busy=0, done=0, checksum=0, cpu_hold=1.
REQ-036 Reset during RECV or WRITE SHALL abort the load; a partial word SHALL not be written, and any pending WRITE strobe is suppressed.
REQ-037 Reset SHALL take priority over start and byte_valid on the same edge.

Verification
REQ-038 start with word_count=1, then bytes 13,04,30,00 -> one we_IM pulse, addr_wr=0, data_wr=0x00300413, checksum=0x47, then done=1 and cpu_hold=0.
REQ-039 word_count=2 with byte_valid gaps of 0–3 cycles between bytes -> writes 0x00100493@0 and 0x01000913@1, each we_IM exactly 1 cycle, byte_ready=0 during each WRITE.
REQ-040 word_count=40, 128 bytes -> 32 writes at addresses 0..31, DONE after the addr 31 write, and further byte_valid is not accepted.
REQ-041 start with word_count=0 -> DONE next cycle, no we_IM, checksum=0.
REQ-042 reset after 2 bytes of word 0 -> IDLE, no we_IM, cpu_hold=1; new start with word_count=1 and bytes 33,04,00,00 -> data_wr=0x00000433@0.
REQ-043 start asserted during RECV -> ignored (target and address unchanged); start asserted in DONE -> reload from address 0 with checksum cleared.
